alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Parametrised successor to the EX-stage ALU control decoder. It decodes `funct`/`aluop` into a widened ALU `select`, covering nor/xor/sltu and optionally shifts. It also runs a multi-cycle multiply/divide sequencer that stalls the pipeline and writes HI/LO on completion. It sits between the ID/EX latch and the ALU / mul-div unit, and drives the hazard unit's stall input.

## Interface
- `SEL_W`, default 4: width of `select`; must be at least 4. Legacy 3-bit codes are zero-extended.
- `MD_CYCLES`, default 32: total stall cycles per mult/div; must be at least 2.
- `CNT_W`, default 6: sequencer counter width; must satisfy 2^CNT_W ≥ MD_CYCLES.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `funct`, input, 6: function field from the ID/EX latch.
- `aluop`, input, 2: 00 = lw/sw, 01 = beq, 10 = R-type, 11 = unknown.
- `valid`, input, 1: a real instruction occupies EX (not a bubble).
- `flush`, input, 1: EX is being squashed this cycle.
- `select`, output, SEL_W: ALU control, combinational.
- `stall`, output, 1: hold IF/ID/EX.
- `md_start`, output, 1: one-cycle pulse that launches the mul/div unit.
- `md_op`, output, 2: 00 = mult, 01 = multu, 10 = div, 11 = divu.
- `md_done`, output, 1: one-cycle completion pulse.
- `hilo_we`, output, 1: HI/LO write enable.
- `illegal`, output, 1: sticky flag for an undefined R-type funct.

## Operation
- Select codes:
  - and 0000, or 0001, add 0010, don't-care (ALUx) 0011, sub 0110, slt 0111.
  - nor 1100, xor 1101, sltu 1111.
  - sll 1000, srl 1001, sra 1010 (only with the macro defined).
- Decode by `aluop`:
  - 00: add.
  - 01: sub.
  - 11: ALUx.
  - 10 (R-type), by funct: add 100000, sub 100010, and 100100, or 100101, nor 100111, xor 100110, slt 101010, sltu 101011.
  - 10 with mult 011000, multu 011001, div 011010, divu 011011: `select` = ALUx.
  - 10 with any other funct: ALUx.
- Every `aluop` value is decoded; `select` never holds a previous value.
- `illegal` sets on `valid & aluop==10 & undefined funct`. It is cleared only by `rst`.
- Mult/div sequencer FSM:
  - Define `md_req = valid & aluop==10 & funct` in 0110xx.
  - States are IDLE, BUSY and DONE.
  - IDLE: if `md_req & !flush`, latch `md_op = funct[1:0]`, pulse `md_start`, load `cnt = MD_CYCLES-2`, go to BUSY. Otherwise stay in IDLE.
  - BUSY: if `flush`, go to IDLE; this is an abort, so there is no `md_done` and no `hilo_we`. Else if `cnt==0`, go to DONE. Else decrement `cnt`.
  - DONE: assert `md_done=1` and `hilo_we=1`, then go to IDLE unconditionally. `md_req` is ignored in DONE, because the same instruction is still in EX.
- `stall = (IDLE & md_req & !flush) | BUSY`. It is 0 in DONE.
- `md_op` holds stable from the `md_start` cycle through DONE.

## Timing
- `select` is combinational: zero latency from `funct`/`aluop`. It is unaffected by `rst`.
- Reset state: FSM in IDLE, `cnt`=0, `md_op`=00, `illegal`=0.
- Outputs while `rst` is high: `stall`, `md_start`, `md_done` and `hilo_we` all 0.
- Mult/div timeline, with the start at cycle 0:
  - Cycle 0 (IDLE): `stall`=1, `md_start`=1.
  - Cycles 1..MD_CYCLES-1 (BUSY): `stall`=1.
  - Cycle MD_CYCLES (DONE): `stall`=0, `md_done`=1, `hilo_we`=1. The instruction leaves EX at the end of this cycle.
  - Total: exactly MD_CYCLES stall cycles.
- `md_start`, `md_done` and `hilo_we` are each high for exactly one cycle per operation.
- Simultaneous `flush` and `md_req` in IDLE: no start, no stall.
- `flush` in BUSY: the FSM reaches IDLE next cycle, and `stall` drops in that cycle.
- `rst` mid-operation: IDLE next cycle, no `hilo_we`.
- `cnt` never underflows: the BUSY exit at 0 takes priority over the decrement.

## Configuration
- Macro: `ALU_CTRL_SHIFT_EN`.
- Defined: R-type funct sll 000000, srl 000010, sra 000011 decode to 1000, 1001, 1010. They do not set `illegal`.
- Undefined: those functs decode to ALUx and set `illegal` when `valid`.
- The sequencer is identical in both builds.

## Test plan
- Decode sweep: aluop=00 -> 0010; aluop=01 -> 0110; aluop=11 -> 0011; aluop=10 with funct 100111 -> 1100; aluop=10 with funct 101011 -> 1111; aluop=10 with funct 111111 and valid=1 -> `select`=0011 and `illegal`=1 from the next cycle, held until `rst`.
- Mult with MD_CYCLES=32: valid, aluop=10, funct=011000 held -> `md_start` at cycle 0, `stall` high for cycles 0–31, `md_done`/`hilo_we` at cycle 32, `md_op`=00 throughout.
- Divu, then an immediate second divu in the next cycle after DONE -> two `md_start` pulses 33 cycles apart, `md_op`=11, no `md_start` in a DONE cycle.
- `flush` at cycle 10 of a div -> `stall` 0 from cycle 11, `md_done` and `hilo_we` never asserted, FSM in IDLE.
- `rst` at cycle 5 of a multu -> all pulses 0, `stall` 0 next cycle, `illegal`=0, `md_op`=00.
- Shift decode: funct 000011 with aluop=10 -> `select` 1010 with `ALU_CTRL_SHIFT_EN` defined; 0011 plus `illegal` without it.

Source files
------------

// File: rtl/alu_ctrl_seq.sv
// EX-stage ALU control decoder with a multi-cycle mult/div stall sequencer.
// Optional shift decode is enabled by defining the macro ALU_CTRL_SHIFT_EN.
module alu_ctrl_seq #(
  parameter int SEL_W     = 4,
  parameter int MD_CYCLES = 32,
  parameter int CNT_W     = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       funct,
  input  logic [1:0]       aluop,
  input  logic             valid,
  input  logic             flush,
  output logic [SEL_W-1:0] select,
  output logic             stall,
  output logic             md_start,
  output logic [1:0]       md_op,
  output logic             md_done,
  output logic             hilo_we,
  output logic             illegal
);

  localparam logic [3:0] SEL_AND  = 4'b0000;
  localparam logic [3:0] SEL_OR   = 4'b0001;
  localparam logic [3:0] SEL_ADD  = 4'b0010;
  localparam logic [3:0] SEL_ALUX = 4'b0011;
  localparam logic [3:0] SEL_SUB  = 4'b0110;
  localparam logic [3:0] SEL_SLT  = 4'b0111;
  localparam logic [3:0] SEL_NOR  = 4'b1100;
  localparam logic [3:0] SEL_XOR  = 4'b1101;
  localparam logic [3:0] SEL_SLTU = 4'b1111;
`ifdef ALU_CTRL_SHIFT_EN
  localparam logic [3:0] SEL_SLL  = 4'b1000;
  localparam logic [3:0] SEL_SRL  = 4'b1001;
  localparam logic [3:0] SEL_SRA  = 4'b1010;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       md_op_q;
  logic [3:0]       rtype_sel;
  logic             rtype_legal;
  logic [3:0]       sel4;
  logic             md_req;
  logic             start;

  // R-type funct table; mult/div functs are legal but leave the ALU idle.
  always_comb begin
    rtype_sel   = SEL_ALUX;
    rtype_legal = 1'b0;
    case (funct)
      6'b100000: begin rtype_sel = SEL_ADD;  rtype_legal = 1'b1; end
      6'b100010: begin rtype_sel = SEL_SUB;  rtype_legal = 1'b1; end
      6'b100100: begin rtype_sel = SEL_AND;  rtype_legal = 1'b1; end
      6'b100101: begin rtype_sel = SEL_OR;   rtype_legal = 1'b1; end
      6'b100111: begin rtype_sel = SEL_NOR;  rtype_legal = 1'b1; end
      6'b100110: begin rtype_sel = SEL_XOR;  rtype_legal = 1'b1; end
      6'b101010: begin rtype_sel = SEL_SLT;  rtype_legal = 1'b1; end
      6'b101011: begin rtype_sel = SEL_SLTU; rtype_legal = 1'b1; end
      6'b011000, 6'b011001, 6'b011010, 6'b011011: rtype_legal = 1'b1;
`ifdef ALU_CTRL_SHIFT_EN
      6'b000000: begin rtype_sel = SEL_SLL;  rtype_legal = 1'b1; end
      6'b000010: begin rtype_sel = SEL_SRL;  rtype_legal = 1'b1; end
      6'b000011: begin rtype_sel = SEL_SRA;  rtype_legal = 1'b1; end
`endif
      default: ;
    endcase
  end

  always_comb begin
    sel4 = SEL_ALUX;
    case (aluop)
      2'b00:   sel4 = SEL_ADD;
      2'b01:   sel4 = SEL_SUB;
      2'b10:   sel4 = rtype_sel;
      default: sel4 = SEL_ALUX;
    endcase
  end

  assign select = SEL_W'(sel4);

  assign md_req   = valid & (aluop == 2'b10) & (funct[5:2] == 4'b0110);
  assign start    = ~rst & (state == IDLE) & md_req & ~flush;
  assign stall    = start | (~rst & (state == BUSY));
  assign md_start = start;
  assign md_done  = ~rst & (state == DONE);
  assign hilo_we  = ~rst & (state == DONE);
  // The op is visible in the launch cycle, before the latch has captured it.
  assign md_op    = start ? funct[1:0] : md_op_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      md_op_q <= 2'b00;
      illegal <= 1'b0;
    end else begin
      if (valid && (aluop == 2'b10) && !rtype_legal)
        illegal <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            md_op_q <= funct[1:0];
            cnt     <= CNT_W'(MD_CYCLES - 2);
            state   <= BUSY;
          end
        end
        BUSY: begin
          if (flush)
            state <= IDLE;
          else if (cnt == '0)
            state <= DONE;
          else
            cnt <= cnt - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: directed scenarios plus randomized
// traffic against a cycle-age reference model. Honours ALU_CTRL_SHIFT_EN.
module tb_alu_ctrl_seq;

  localparam int MD = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] funct = '0;
  logic [1:0] aluop = '0;
  logic       valid = 1'b0;
  logic       flush = 1'b0;
  logic [3:0] select;
  logic       stall, md_start, md_done, hilo_we, illegal;
  logic [1:0] md_op;

  int n_tests = 0;
  int n_fail  = 0;

  alu_ctrl_seq #(.SEL_W(4), .MD_CYCLES(MD), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .funct(funct), .aluop(aluop), .valid(valid),
    .flush(flush), .select(select), .stall(stall), .md_start(md_start),
    .md_op(md_op), .md_done(md_done), .hilo_we(hilo_we), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct { logic [5:0] f; logic [3:0] c; } ent_t;
  ent_t tbl[$];

  function automatic bit ref_legal(input logic [5:0] f);
    foreach (tbl[i]) if (tbl[i].f == f) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [3:0] ref_select(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0011;
    foreach (tbl[i]) if (tbl[i].f == f) return tbl[i].c;
    return 4'b0011;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_reset();
    rst = 1'b1; valid = 1'b0; flush = 1'b0; aluop = 2'b00; funct = '0;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid = 1'b1; aluop = 2'b10; funct = 6'b011000; flush = 1'b0;
    #1;
    n_tests++;
    if ({stall, md_start, md_done, hilo_we} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0000", {stall, md_start, md_done, hilo_we});
    end
    n_tests++;
    if (select !== 4'b0011) begin
      n_fail++; $display("FAIL reset_select: got %b expected 0011", select);
    end
    next_cycle();
    aluop = 2'b01;
    #1;
    n_tests++;
    if ({illegal, md_op, stall} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_state: got %b expected 0000", {illegal, md_op, stall});
    end
    n_tests++;
    if (select !== 4'b0110) begin
      n_fail++; $display("FAIL reset_select_sub: got %b expected 0110", select);
    end
    rst = 1'b0; valid = 1'b0;
    next_cycle();
    n_tests++;
    if ({illegal, md_op, stall, md_done} !== 5'b00000) begin
      n_fail++; $display("FAIL post_reset: got %b expected 00000", {illegal, md_op, stall, md_done});
    end
  endtask

  task automatic test_decode();
    logic [1:0] ops [6] = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10, 2'b10};
    logic [5:0] fns [6] = '{6'b101010, 6'b100000, 6'b100100, 6'b100111, 6'b101011, 6'b100110};
    logic [3:0] exp [6] = '{4'b0010, 4'b0110, 4'b0011, 4'b1100, 4'b1111, 4'b1101};
    quiet_reset();
    valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      aluop = ops[i]; funct = fns[i];
      #1;
      n_tests++;
      if (select !== exp[i]) begin
        n_fail++; $display("FAIL decode_%0d: got %b expected %b", i, select, exp[i]);
      end
    end
    aluop = 2'b10; funct = 6'b111111;
    #1;
    n_tests++;
    if ({select, illegal} !== 5'b0011_0) begin
      n_fail++; $display("FAIL undef_same_cycle: got %b expected 00110", {select, illegal});
    end
    next_cycle();
    funct = 6'b100000;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++;
      if (illegal !== 1'b1) begin
        n_fail++; $display("FAIL illegal_sticky_%0d: got %b expected 1", i, illegal);
      end
      next_cycle();
    end
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; valid = 1'b0;
    #1;
    n_tests++;
    if (illegal !== 1'b0) begin
      n_fail++; $display("FAIL illegal_clear: got %b expected 0", illegal);
    end
  endtask

  task automatic test_shift();
    logic [3:0] e_sel;
    logic       e_ill;
`ifdef ALU_CTRL_SHIFT_EN
    e_sel = 4'b1010; e_ill = 1'b0;
`else
    e_sel = 4'b0011; e_ill = 1'b1;
`endif
    quiet_reset();
    valid = 1'b1; aluop = 2'b10; funct = 6'b000011;
    #1;
    n_tests++;
    if (select !== e_sel) begin
      n_fail++; $display("FAIL shift_sra_select: got %b expected %b", select, e_sel);
    end
    next_cycle();
    valid = 1'b0;
    #1;
    n_tests++;
    if (illegal !== e_ill) begin
      n_fail++; $display("FAIL shift_illegal: got %b expected %b", illegal, e_ill);
    end
  endtask

  task automatic test_mult();
    logic [3:0] e;
    quiet_reset();
    valid = 1'b1; aluop = 2'b10; funct = 6'b011000;
    for (int c = 0; c <= MD + 1; c++) begin
      if (c == MD + 1) valid = 1'b0;
      #1;
      e = {(c < MD), (c == 0), (c == MD), (c == MD)};
      n_tests++;
      if ({stall, md_start, md_done, hilo_we} !== e) begin
        n_fail++; $display("FAIL mult_c%0d: got %b expected %b", c, {stall, md_start, md_done, hilo_we}, e);
      end
      if (c <= MD) begin
        n_tests++;
        if (md_op !== 2'b00) begin
          n_fail++; $display("FAIL mult_op_c%0d: got %b expected 00", c, md_op);
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    int starts[$];
    quiet_reset();
    valid = 1'b1; aluop = 2'b10; funct = 6'b011011;
    for (int c = 0; c < 2 * (MD + 1); c++) begin
      #1;
      if (md_start) starts.push_back(c);
      n_tests++;
      if (md_op !== 2'b11) begin
        n_fail++; $display("FAIL divu_op_c%0d: got %b expected 11", c, md_op);
      end
      if (md_done) begin
        n_tests++;
        if (md_start !== 1'b0 || stall !== 1'b0) begin
          n_fail++; $display("FAIL divu_done_c%0d: start=%b stall=%b expected 0 0", c, md_start, stall);
        end
      end
      next_cycle();
    end
    valid = 1'b0;
    n_tests++;
    if (starts.size() != 2 || starts[0] != 0 || starts[1] != MD + 1) begin
      n_fail++;
      $display("FAIL divu_starts: got %0d pulses first=%0d second=%0d expected 2 at 0 and %0d",
               starts.size(), (starts.size() > 0) ? starts[0] : -1,
               (starts.size() > 1) ? starts[1] : -1, MD + 1);
    end
  endtask

  task automatic test_flush();
    int dones;
    quiet_reset();
    dones = 0;
    valid = 1'b1; aluop = 2'b10; funct = 6'b011010;
    for (int c = 0; c < 50; c++) begin
      flush = (c == 10);
      if (c == 11) valid = 1'b0;
      #1;
      dones += int'(md_done) + int'(hilo_we);
      n_tests++;
      if (stall !== (c <= 10)) begin
        n_fail++; $display("FAIL flush_stall_c%0d: got %b expected %b", c, stall, (c <= 10));
      end
      next_cycle();
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++; $display("FAIL flush_no_done: got %0d pulses expected 0", dones);
    end
  endtask

  task automatic test_rst_mid();
    int dones;
    quiet_reset();
    dones = 0;
    valid = 1'b1; aluop = 2'b10; funct = 6'b011001;
    for (int c = 0; c < 45; c++) begin
      rst = (c == 5);
      if (c == 6) valid = 1'b0;
      #1;
      if (c > 5) dones += int'(md_done) + int'(hilo_we);
      if (c == 1) begin
        n_tests++;
        if (md_op !== 2'b01) begin
          n_fail++; $display("FAIL multu_op: got %b expected 01", md_op);
        end
      end
      if (c == 5) begin
        n_tests++;
        if ({stall, md_start, md_done, hilo_we} !== 4'b0000) begin
          n_fail++; $display("FAIL rst_mid_during: got %b expected 0000", {stall, md_start, md_done, hilo_we});
        end
      end
      if (c == 6) begin
        n_tests++;
        if ({stall, md_start, illegal, md_op} !== 5'b00000) begin
          n_fail++; $display("FAIL rst_mid_after: got %b expected 00000", {stall, md_start, illegal, md_op});
        end
      end
      next_cycle();
    end
    n_tests++;
    if (dones != 0) begin
      n_fail++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", dones);
    end
  endtask

  task automatic test_random();
    logic [5:0] picks [10] = '{6'b011000, 6'b011001, 6'b011010, 6'b011011, 6'b100000,
                               6'b100111, 6'b000011, 6'b111111, 6'b101011, 6'b000010};
    bit         m_active, m_ill, req, st;
    int         m_age;
    logic [1:0] m_op;
    logic [6:0] e, got;
    logic [3:0] e_sel;
    quiet_reset();
    m_active = 0; m_age = 0; m_op = 2'b00; m_ill = 0;
    for (int i = 0; i < 800; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      valid = ($urandom_range(0, 7) != 0);
      aluop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      funct = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : picks[$urandom_range(0, 9)];
      flush = ($urandom_range(0, 39) == 0);
      #1;
      req = valid && aluop == 2'b10 && funct >= 6'd24 && funct <= 6'd27;
      st  = !rst && !m_active && req && !flush;
      e   = '0;
      if (!rst) begin
        if (!m_active) e[6:5] = {st, st};
        else if (m_age < MD) e[6] = 1'b1;
        else e[4:3] = 2'b11;
      end
      e[2:1] = st ? funct[1:0] : m_op;
      e[0]   = m_ill;
      got    = {stall, md_start, md_done, hilo_we, md_op, illegal};
      e_sel  = ref_select(aluop, funct);
      n_tests++;
      if (got !== e) begin
        n_fail++; $display("FAIL rand_ctrl_%0d: got %b expected %b", i, got, e);
      end
      n_tests++;
      if (select !== e_sel) begin
        n_fail++; $display("FAIL rand_select_%0d: got %b expected %b", i, select, e_sel);
      end
      if (rst) begin
        m_active = 0; m_op = 2'b00; m_ill = 0;
      end else begin
        if (valid && aluop == 2'b10 && !ref_legal(funct)) m_ill = 1;
        if (!m_active) begin
          if (st) begin m_active = 1; m_age = 1; m_op = funct[1:0]; end
        end else if (m_age < MD) begin
          if (flush) m_active = 0; else m_age++;
        end else m_active = 0;
      end
      next_cycle();
    end
  endtask

  initial begin
    tbl.push_back('{6'b100000, 4'b0010}); tbl.push_back('{6'b100010, 4'b0110});
    tbl.push_back('{6'b100100, 4'b0000}); tbl.push_back('{6'b100101, 4'b0001});
    tbl.push_back('{6'b100111, 4'b1100}); tbl.push_back('{6'b100110, 4'b1101});
    tbl.push_back('{6'b101010, 4'b0111}); tbl.push_back('{6'b101011, 4'b1111});
    tbl.push_back('{6'b011000, 4'b0011}); tbl.push_back('{6'b011001, 4'b0011});
    tbl.push_back('{6'b011010, 4'b0011}); tbl.push_back('{6'b011011, 4'b0011});
`ifdef ALU_CTRL_SHIFT_EN
    tbl.push_back('{6'b000000, 4'b1000}); tbl.push_back('{6'b000010, 4'b1001});
    tbl.push_back('{6'b000011, 4'b1010});
`endif
    #1;
    test_reset();
    test_decode();
    test_shift();
    test_mult();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
